keypad_entry: RTL
=================

# keypad_entry

Parametrised successor to the alarm-clock keypad shifter. It debounces a 10-button one-hot keypad, rejects multi-key presses, and shifts each accepted digit as a BCD nibble into an N-digit entry register. It reports digit count and full status and supports a synchronous clear. It sits between the raw button inputs and the time/alarm-set logic, which reads `keypad_values` and clears it after use.

## Interface
- `NUM_DIGITS`, default 4: number of BCD digits held; range 1–8.
- `DEBOUNCE_CYCLES`, default 4: number of consecutive identical samples required to accept a press or a release; minimum 1.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `keypad_buttons` in 10: bit i high means digit key i is pressed.
- `keypad_clear` in 1: synchronous clear of the entry register and digit count.
- `keypad_values` out 4*NUM_DIGITS: BCD digits; most recent digit in [3:0].
- `shift_pulse` out 1: one-cycle pulse on each accepted digit.
- `last_key` out 4: BCD value of the most recently accepted key.
- `digit_count` out $clog2(NUM_DIGITS+1): number of digits entered since the last clear; saturates at NUM_DIGITS.
- `full` out 1: high when `digit_count == NUM_DIGITS`.

## Operation
- The `keypad_buttons` input is registered once (`btn_q`). All decisions use `btn_q`.
- States:
  - **IDLE**: `btn_q == 0`.
  - **PRESS_DB**: counting a stable one-hot pattern.
  - **HELD**: press accepted, waiting for release.
  - **RELEASE_DB**: counting a stable all-zero input.
- Transitions:
  - IDLE → PRESS_DB when `btn_q` is exactly one-hot.
  - IDLE → HELD when `btn_q` is non-zero and not one-hot. This is an invalid chord: no digit is accepted, but the block still requires a release.
  - PRESS_DB → IDLE if `btn_q` changes to 0.
  - PRESS_DB restarts its count if `btn_q` changes to a different non-zero value. A different one-hot value restarts counting that value; a non-one-hot value moves to HELD.
  - PRESS_DB → HELD when the count reaches DEBOUNCE_CYCLES. This is the **accept** event.
  - HELD → RELEASE_DB when `btn_q == 0`.
  - RELEASE_DB → HELD if `btn_q` becomes non-zero.
  - RELEASE_DB → IDLE after DEBOUNCE_CYCLES consecutive zero samples.
- On accept:
  - `keypad_values` shifts left by 4 and the new BCD digit enters [3:0]. The oldest digit is discarded.
  - `last_key` updates to the accepted digit.
  - `digit_count` increments, saturating at NUM_DIGITS.
  - `shift_pulse` is high for 1 cycle.
- A key held indefinitely produces exactly one accept. There is no auto-repeat.
- `keypad_clear` sets `keypad_values` and `digit_count` to 0. `last_key` and the FSM state are unaffected.
- Clear coincident with an accept: clear wins. The digit is dropped and `shift_pulse` stays 0. The FSM still goes to HELD.

## Timing
- Reset (`reset_n` low at an edge):
  - Outputs: `keypad_values` = 0, `shift_pulse` = 0, `last_key` = 0, `digit_count` = 0, `full` = 0.
  - Internal: FSM in IDLE, `btn_q` = 0, debounce counter = 0.
- Reset has priority over every other input, including mid-debounce. The pending press is lost, and a still-held key must pass a full press debounce after reset.
- Accept latency: the one-hot pattern must be present at the input on D = DEBOUNCE_CYCLES consecutive edges, E0 through E0+D-1.
  - At edge E0+D, the new `keypad_values`, `last_key` and `digit_count` are visible, and `shift_pulse` is high.
  - `shift_pulse` drops at edge E0+D+1.
- Release: after the all-zero pattern has been sampled at D consecutive edges, the FSM is in IDLE. The next press can begin counting from the following edge.
- `full` is combinational from `digit_count`.

## Configuration
- Macro: `KEYPAD_ENTRY_FULL_LOCK_EN`.
- Defined: when `full == 1`, accepts are ignored:
  - No shift, `shift_pulse` stays 0, `last_key` is unchanged.
  - The FSM still runs IDLE→PRESS_DB→HELD→RELEASE_DB.
  - Entry resumes only after `keypad_clear` or reset.
- Undefined: shifting continues past full, discarding the oldest digit, and `full` remains 1.

## Structure
- Package `keypad_pkg` contains:
  - the FSM state enum;
  - the constant `KEYPAD_NUM_KEYS = 10`;
  - the function `onehot_to_bcd(10-bit) → 4-bit`;
  - the function `is_onehot(10-bit)`.
- Sub-module `keypad_debounce` contains:
  - the `btn_q` register;
  - the compare-and-count logic, which outputs `stable` and `stable_value`.
- `keypad_entry` contains the FSM, the shift register and the counters.

## Test plan
All scenarios use NUM_DIGITS=4, DEBOUNCE_CYCLES=2, with each key held for 6 cycles and released for 6 cycles.
- Keys 1, 2, 3, 4 → `keypad_values` = 16'h1234, `digit_count` = 4, `full` = 1, exactly 4 `shift_pulse` cycles. Each pulse occurs 2 edges after the press first appears.
- Key 5 pressed after 16'h1234:
  - macro off → 16'h2345, `last_key` = 5;
  - macro on → stays 16'h1234, no pulse.
- Key 7 pressed for 1 cycle, then 0 → no pulse, values unchanged. Key 7 held 20 cycles → exactly 1 pulse.
- Keys 3 and 8 together (10'h108) → no pulse. After release, key 9 → accepted with `last_key` = 9.
- `keypad_clear` on the same edge as an accept → values = 0, `digit_count` = 0, `shift_pulse` = 0. The next key 6 gives 16'h0006.
- `reset_n` low for 1 cycle mid-PRESS_DB, then high while key 2 is still held → all outputs 0. Key 2 is accepted 2 edges after reset is released → 16'h0002.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the keypad entry block.
//   kp_state_t      - debounce/acceptance FSM states
//   KEYPAD_NUM_KEYS - number of digit keys (0..9)
//   is_onehot()     - exactly one key asserted
//   onehot_to_bcd() - index of the asserted key as a BCD nibble
package keypad_pkg;

   localparam int KEYPAD_NUM_KEYS = 10;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_PRESS_DB   = 2'd1,
      ST_HELD       = 2'd2,
      ST_RELEASE_DB = 2'd3
   } kp_state_t;

   function automatic logic is_onehot(input logic [KEYPAD_NUM_KEYS-1:0] v);
      logic seen;
      logic multi;
      seen  = 1'b0;
      multi = 1'b0;
      for (int i = 0; i < KEYPAD_NUM_KEYS; i++) begin
         if (v[i]) begin
            if (seen) multi = 1'b1;
            seen = 1'b1;
         end
      end
      return seen & ~multi;
   endfunction

   // Only meaningful for one-hot inputs; the OR-reduction of indices keeps
   // the logic flat instead of a priority chain.
   function automatic logic [3:0] onehot_to_bcd(input logic [KEYPAD_NUM_KEYS-1:0] v);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 0; i < KEYPAD_NUM_KEYS; i++) begin
         if (v[i]) r = r | 4'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: registers the raw buttons once and measures how long the
// registered pattern has been steady.
//   clk, reset_n   - clock, synchronous active-low reset
//   keypad_buttons - raw key inputs
//   stable         - the sample btn_q presents at this edge is the
//                    DEBOUNCE_CYCLES-th consecutive identical one
//   stable_value   - btn_q
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [KEYPAD_NUM_KEYS-1:0] keypad_buttons,
   output logic                       stable,
   output logic [KEYPAD_NUM_KEYS-1:0] stable_value
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [KEYPAD_NUM_KEYS-1:0] btn_q;
   logic [CW-1:0]              cnt;

   // cnt = number of earlier edges that already consumed the current btn_q
   // value; it returns to 0 whenever btn_q is about to take a new value.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         btn_q <= '0;
         cnt   <= '0;
      end else begin
         btn_q <= keypad_buttons;
         if (keypad_buttons != btn_q)
            cnt <= '0;
         else if (cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
      end
   end

   assign stable       = (cnt >= CNT_LAST);
   assign stable_value = btn_q;

endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: debounced 10-key keypad feeding an N-digit BCD shift register.
//   clk, reset_n   - clock, synchronous active-low reset
//   keypad_buttons - one-hot digit keys (bit i = key i)
//   keypad_clear   - clears entry register and digit count (wins over accept)
//   keypad_values  - BCD digits, newest in [3:0]
//   shift_pulse    - one-cycle pulse per stored digit
//   last_key       - most recently stored digit
//   digit_count    - digits entered since clear, saturating at NUM_DIGITS
//   full           - digit_count == NUM_DIGITS
// Build option: KEYPAD_ENTRY_FULL_LOCK_EN - when defined, accepts are ignored
// while full until a clear or reset.
module keypad_entry
   import keypad_pkg::*;
#(
   parameter int NUM_DIGITS      = 4,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic [KEYPAD_NUM_KEYS-1:0]         keypad_buttons,
   input  logic                               keypad_clear,
   output logic [4*NUM_DIGITS-1:0]            keypad_values,
   output logic                               shift_pulse,
   output logic [3:0]                         last_key,
   output logic [$clog2(NUM_DIGITS+1)-1:0]    digit_count,
   output logic                               full
);

   localparam int CW = $clog2(NUM_DIGITS + 1);
   localparam logic [CW-1:0] COUNT_MAX = CW'(NUM_DIGITS);

   logic                       stable;
   logic [KEYPAD_NUM_KEYS-1:0] btn_q;
   logic                       btn_nz;
   logic                       btn_oh;
   logic [3:0]                 digit;
   kp_state_t                  state;
   kp_state_t                  state_nxt;
   logic                       accept;
   logic                       take;
   logic [4*NUM_DIGITS-1:0]    values_shifted;

   keypad_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk            (clk),
      .reset_n        (reset_n),
      .keypad_buttons (keypad_buttons),
      .stable         (stable),
      .stable_value   (btn_q)
   );

   assign btn_nz = |btn_q;
   assign btn_oh = is_onehot(btn_q);
   assign digit  = onehot_to_bcd(btn_q);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   // With DEBOUNCE_CYCLES == 1 the first sample already completes the
   // debounce, so IDLE/HELD may skip straight past the counting states.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (btn_nz) begin
               if (!btn_oh)     state_nxt = ST_HELD;      // chord: wait for release
               else if (stable) state_nxt = ST_HELD;
               else             state_nxt = ST_PRESS_DB;
            end
         end
         ST_PRESS_DB: begin
            // A different one-hot value restarts the count inside the debouncer.
            if (!btn_nz)     state_nxt = ST_IDLE;
            else if (!btn_oh) state_nxt = ST_HELD;
            else if (stable)  state_nxt = ST_HELD;
         end
         ST_HELD: begin
            if (!btn_nz) state_nxt = stable ? ST_IDLE : ST_RELEASE_DB;
         end
         ST_RELEASE_DB: begin
            if (btn_nz)      state_nxt = ST_HELD;
            else if (stable) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      accept = 1'b0;
      if ((state == ST_IDLE || state == ST_PRESS_DB) && btn_oh && stable)
         accept = 1'b1;
   end

   // ---------------- entry register ----------------
   assign full = (digit_count == COUNT_MAX);

`ifdef KEYPAD_ENTRY_FULL_LOCK_EN
   assign take = accept & ~keypad_clear & ~full;
`else
   assign take = accept & ~keypad_clear;
`endif

   generate
      if (NUM_DIGITS == 1) begin : g_one
         assign values_shifted = digit;
      end else begin : g_many
         assign values_shifted = {keypad_values[4*NUM_DIGITS-5:0], digit};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         keypad_values <= '0;
         shift_pulse   <= 1'b0;
         last_key      <= 4'd0;
         digit_count   <= '0;
      end else begin
         shift_pulse <= take;
         if (keypad_clear) begin
            keypad_values <= '0;
            digit_count   <= '0;
         end else if (take) begin
            keypad_values <= values_shifted;
            last_key      <= digit;
            if (digit_count != COUNT_MAX)
               digit_count <= digit_count + 1'b1;
         end
      end
   end

endmodule
